// File: rtl/cache_snoop_responder_if.sv
// Bus-side snoop, writeback and directory-fill signals of cache_snoop_responder.
// master: the requesting side (other caches / cache core); slave: the responder.
interface cache_snoop_responder_if #(
  parameter int WAYS = 4
);
  localparam int WAYS_REP = $clog2(WAYS);

  logic                snp_valid;
  logic [1:0]          snp_op;
  logic [31:0]         snp_addr;
  logic                snp_ready;
  logic                snp_res_valid;
  logic [1:0]          C;
  logic                wb_valid;
  logic [31:0]         wb_addr;
  logic                wb_ready;
  logic                fill_valid;
  logic [31:0]         fill_addr;
  logic [WAYS_REP-1:0] fill_way;
  logic [1:0]          fill_mesi;
  logic                fill_ready;

  modport master (
    output snp_valid, snp_op, snp_addr, wb_ready,
           fill_valid, fill_addr, fill_way, fill_mesi,
    input  snp_ready, snp_res_valid, C, wb_valid, wb_addr, fill_ready
  );

  modport slave (
    input  snp_valid, snp_op, snp_addr, wb_ready,
           fill_valid, fill_addr, fill_way, fill_mesi,
    output snp_ready, snp_res_valid, C, wb_valid, wb_addr, fill_ready
  );
endinterface

// File: rtl/cache_snoop_responder.sv
// cache_snoop_responder: looks snooped bus operations up in the local tag/MESI
// directory, returns HIT / HITM / NOHIT, applies the MESI downgrade or
// invalidate and requests a line writeback when a Modified line is snooped.
// Optional feature macro: SNOOP_CNTR_EN (HIT/HITM counters; tied to 0 when undefined).
module cache_snoop_responder #(
  parameter int NUM_SETS = 16,
  parameter int WAYS     = 4,
  parameter int BYTE     = 6
) (
  input  logic                    clk,
  input  logic                    rstb,
  cache_snoop_responder_if.slave  bus,
  output logic [15:0]             hit_cntr,
  output logic [15:0]             hitm_cntr
);
  localparam int INDEX    = $clog2(NUM_SETS);
  localparam int WAYS_REP = $clog2(WAYS);
  localparam int TAG      = 32 - INDEX - BYTE;
  localparam int LINE     = 32 - BYTE;

  typedef enum logic [1:0] {MESI_I = 2'd0, MESI_S = 2'd1, MESI_E = 2'd2, MESI_M = 2'd3} mesi_e;
  typedef enum logic [1:0] {OP_READ = 2'd0, OP_WRITE = 2'd1, OP_INVALIDATE = 2'd2, OP_RWIM = 2'd3} op_e;
  typedef enum logic [1:0] {RES_HIT = 2'b00, RES_HITM = 2'b01, RES_NOHIT = 2'b10} res_e;
  typedef enum logic [1:0] {ST_IDLE, ST_LOOKUP, ST_RESP, ST_WB} state_e;

  state_e              state;
  logic [TAG-1:0]      dir_tag  [NUM_SETS][WAYS];
  mesi_e               dir_mesi [NUM_SETS][WAYS];

  logic [LINE-1:0]     req_line;
  op_e                 req_op;
  logic [INDEX-1:0]    req_index;
  logic [TAG-1:0]      req_tag;

  logic                lk_hit;
  logic [WAYS_REP-1:0] lk_way;
  mesi_e               lk_cur;
  mesi_e               lk_next;
  res_e                lk_res;

  logic                rsp_hit;
  logic [WAYS_REP-1:0] rsp_way;
  mesi_e               rsp_next;

  res_e                res_c;
  logic                res_valid;
  logic                wb_valid_q;
  logic [31:0]         wb_addr_q;

  logic                snp_fire;
  logic                fill_fire;
  logic [INDEX-1:0]    fill_index;
  logic [TAG-1:0]      fill_tag;
  logic                unused_addr_offsets;

  assign req_index  = req_line[INDEX-1:0];
  assign req_tag    = req_line[LINE-1:INDEX];
  assign fill_index = bus.fill_addr[BYTE+INDEX-1:BYTE];
  assign fill_tag   = bus.fill_addr[31:BYTE+INDEX];
  // Byte offsets never reach the directory; only the line address matters.
  assign unused_addr_offsets = ^{bus.fill_addr[BYTE-1:0], bus.snp_addr[BYTE-1:0]};

  // A fill wins over a snoop presented in the same IDLE cycle.
  assign bus.fill_ready = (state == ST_IDLE) && !rstb;
  assign bus.snp_ready  = (state == ST_IDLE) && !bus.fill_valid && !rstb;
  assign fill_fire      = bus.fill_valid && bus.fill_ready;
  assign snp_fire       = bus.snp_valid && bus.snp_ready;

  assign bus.snp_res_valid = res_valid;
  assign bus.C             = res_c;
  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_addr       = wb_addr_q;

  // Tag compare across the ways of the requested set; lowest matching way wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (dir_mesi[req_index][w] != MESI_I && dir_tag[req_index][w] == req_tag) begin
        lk_hit = 1'b1;
        lk_way = WAYS_REP'(w);
      end
    end
  end

  // Snoop result and next MESI state of the hitting line.
  always_comb begin
    lk_cur  = dir_mesi[req_index][lk_way];
    lk_next = lk_cur;
    lk_res  = RES_NOHIT;
    if (lk_hit) begin
      unique case (req_op)
        OP_READ: begin
          lk_res  = (lk_cur == MESI_M) ? RES_HITM : RES_HIT;
          lk_next = MESI_S;
        end
        OP_WRITE: begin
          lk_res  = RES_NOHIT;
        end
        OP_INVALIDATE: begin
          if (lk_cur == MESI_S) begin
            lk_res  = RES_HIT;
            lk_next = MESI_I;
          end
        end
        OP_RWIM: begin
          lk_res  = (lk_cur == MESI_M) ? RES_HITM : RES_HIT;
          lk_next = MESI_I;
        end
      endcase
    end
  end

  // Directory storage: cleared on reset, written by fills and by the MESI update at the end of RESP.
  always_ff @(posedge clk) begin
    if (rstb) begin
      // NOTE: the directory must read all-Invalid after reset, so it is built from resettable flops rather than a RAM.
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          dir_tag[s][w]  <= '0;
          dir_mesi[s][w] <= MESI_I;
        end
      end
    end else if (fill_fire) begin
      dir_tag[fill_index][bus.fill_way]  <= fill_tag;
      dir_mesi[fill_index][bus.fill_way] <= mesi_e'(bus.fill_mesi);
    end else if (state == ST_RESP && rsp_hit) begin
      dir_mesi[req_index][rsp_way] <= rsp_next;
    end
  end

  // Snoop FSM: IDLE -> LOOKUP -> RESP -> (WB ->) IDLE, all outputs registered.
  always_ff @(posedge clk) begin
    if (rstb) begin
      state      <= ST_IDLE;
      req_line   <= '0;
      req_op     <= OP_READ;
      rsp_hit    <= 1'b0;
      rsp_way    <= '0;
      rsp_next   <= MESI_I;
      res_valid  <= 1'b0;
      res_c      <= RES_NOHIT;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      res_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (snp_fire) begin
            req_line <= bus.snp_addr[31:BYTE];
            req_op   <= op_e'(bus.snp_op);
            state    <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          rsp_hit   <= lk_hit;
          rsp_way   <= lk_way;
          rsp_next  <= lk_next;
          res_c     <= lk_res;
          res_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (res_c == RES_HITM) begin
            wb_valid_q <= 1'b1;
            wb_addr_q  <= {req_line, {BYTE{1'b0}}};
            state      <= ST_WB;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WB: begin
          if (bus.wb_ready) begin
            wb_valid_q <= 1'b0;
            state      <= ST_IDLE;
          end
        end
      endcase
    end
  end

`ifdef SNOOP_CNTR_EN
  // Saturating HIT / HITM counters, stepped on each result strobe.
  always_ff @(posedge clk) begin
    if (rstb) begin
      hit_cntr  <= '0;
      hitm_cntr <= '0;
    end else if (res_valid) begin
      if (res_c == RES_HIT && hit_cntr != 16'hFFFF) begin
        hit_cntr <= hit_cntr + 16'd1;
      end
      if (res_c == RES_HITM && hitm_cntr != 16'hFFFF) begin
        hitm_cntr <= hitm_cntr + 16'd1;
      end
    end
  end
`else
  assign hit_cntr  = 16'h0;
  assign hitm_cntr = 16'h0;
`endif

endmodule

// File: tb/tb_cache_snoop_responder.sv
// Directed bench for cache_snoop_responder: table of fill/snoop vectors with
// hand-computed results, plus hand-written fill/snoop collision and
// reset-during-writeback sequences. Geometry: NUM_SETS=16, WAYS=4, BYTE=6.
module tb_cache_snoop_responder;
  localparam logic [1:0] OP_R = 2'd0, OP_W = 2'd1, OP_INV = 2'd2, OP_X = 2'd3;
  localparam logic [1:0] M_I = 2'd0, M_S = 2'd1, M_E = 2'd2, M_M = 2'd3;
  localparam logic [1:0] C_HIT = 2'b00, C_HITM = 2'b01, C_NOHIT = 2'b10;
`ifdef SNOOP_CNTR_EN
  localparam bit CNTR_EN = 1'b1;
`else
  localparam bit CNTR_EN = 1'b0;
`endif

  typedef struct {
    bit          do_fill;
    logic [31:0] f_addr;
    logic [1:0]  f_way;
    logic [1:0]  f_mesi;
    logic [1:0]  op;
    logic [31:0] s_addr;
    logic [1:0]  exp_c;
    bit          exp_wb;
    logic [31:0] exp_wba;
    int          hold;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  logic        clk = 1'b0;
  logic        rstb = 1'b1;
  logic [15:0] hit_cntr;
  logic [15:0] hitm_cntr;

  int n_checks = 0;
  int n_errors = 0;
  int exp_hit  = 0;
  int exp_hitm = 0;

  cache_snoop_responder_if #(.WAYS(4)) bus ();

  cache_snoop_responder #(.NUM_SETS(16), .WAYS(4), .BYTE(6)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .bus       (bus),
    .hit_cntr  (hit_cntr),
    .hitm_cntr (hitm_cntr)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end, got timeout, expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int v);
    return CNTR_EN ? 32'(v) : 32'd0;
  endfunction

  // Called #1 after a posedge with the DUT in IDLE; returns #1 after the accepting edge.
  task automatic do_fill(input logic [31:0] addr, input logic [1:0] way, input logic [1:0] mesi);
    bus.fill_valid = 1'b1;
    bus.fill_addr  = addr;
    bus.fill_way   = way;
    bus.fill_mesi  = mesi;
    @(negedge clk);
    check("fill_ready", 32'(bus.fill_ready), 32'd1);
    @(posedge clk);
    #1 bus.fill_valid = 1'b0;
  endtask

  // Full snoop transaction with timing checks; returns #1 after a posedge with the DUT back in IDLE.
  task automatic run_snoop(input string name, input logic [1:0] op, input logic [31:0] addr,
                           input logic [1:0] exp_c, input bit exp_wb, input logic [31:0] exp_wba,
                           input int hold);
    bit ok;
    int n;
    bus.snp_valid = 1'b1;
    bus.snp_op    = op;
    bus.snp_addr  = addr;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = bus.snp_ready;
      @(posedge clk);
      n++;
    end
    #1 bus.snp_valid = 1'b0;
    check({name, " accept"}, 32'(ok), 32'd1);
    if (!ok) return;
    check({name, " lookup res_valid"}, 32'(bus.snp_res_valid), 32'd0);
    @(posedge clk); #1;
    check({name, " res_valid"}, 32'(bus.snp_res_valid), 32'd1);
    check({name, " C"}, 32'(bus.C), 32'(exp_c));
    @(posedge clk); #1;
    if (exp_c == C_HIT) exp_hit++;
    else if (exp_c == C_HITM) exp_hitm++;
    check({name, " res_valid drop"}, 32'(bus.snp_res_valid), 32'd0);
    check({name, " C hold"}, 32'(bus.C), 32'(exp_c));
    check({name, " hit_cntr"}, 32'(hit_cntr), cnt_exp(exp_hit));
    check({name, " hitm_cntr"}, 32'(hitm_cntr), cnt_exp(exp_hitm));
    check({name, " wb_valid"}, 32'(bus.wb_valid), 32'(exp_wb));
    if (exp_wb) begin
      for (int i = 0; i < hold; i++) begin
        check({name, " wb_valid stall"}, 32'(bus.wb_valid), 32'd1);
        check({name, " wb_addr stall"}, bus.wb_addr, exp_wba);
        @(posedge clk); #1;
      end
      check({name, " wb_addr"}, bus.wb_addr, exp_wba);
      check({name, " snp_ready in WB"}, 32'(bus.snp_ready), 32'd0);
      bus.wb_ready = 1'b1;
      @(posedge clk);
      #1 bus.wb_ready = 1'b0;
      check({name, " wb_valid after handshake"}, 32'(bus.wb_valid), 32'd0);
    end
    check({name, " back to idle"}, 32'(bus.snp_ready), 32'd1);
  endtask

  initial begin
    bit ok;
    logic [31:0] probes [5];

    // Index = addr[9:6], tag = addr[31:10].
    vecs[0]  = '{0, 32'h0,    2'd0, M_I, OP_R,   32'h1040, C_NOHIT, 0, 32'h0,    0};
    vecs[1]  = '{1, 32'h1040, 2'd2, M_M, OP_R,   32'h107F, C_HITM,  1, 32'h1040, 4};
    vecs[2]  = '{0, 32'h0,    2'd0, M_I, OP_R,   32'h1040, C_HIT,   0, 32'h0,    0};
    vecs[3]  = '{1, 32'h2080, 2'd0, M_E, OP_X,   32'h2080, C_HIT,   0, 32'h0,    0};
    vecs[4]  = '{0, 32'h0,    2'd0, M_I, OP_R,   32'h2080, C_NOHIT, 0, 32'h0,    0};
    vecs[5]  = '{0, 32'h0,    2'd0, M_I, OP_INV, 32'h1040, C_HIT,   0, 32'h0,    0};
    vecs[6]  = '{0, 32'h0,    2'd0, M_I, OP_R,   32'h1040, C_NOHIT, 0, 32'h0,    0};
    vecs[7]  = '{1, 32'h3000, 2'd1, M_M, OP_W,   32'h3000, C_NOHIT, 0, 32'h0,    0};
    vecs[8]  = '{0, 32'h0,    2'd0, M_I, OP_INV, 32'h3000, C_NOHIT, 0, 32'h0,    0};
    vecs[9]  = '{0, 32'h0,    2'd0, M_I, OP_X,   32'h3010, C_HITM,  1, 32'h3000, 0};
    vecs[10] = '{0, 32'h0,    2'd0, M_I, OP_R,   32'h3000, C_NOHIT, 0, 32'h0,    0};
    vecs[11] = '{1, 32'h4040, 2'd3, M_E, OP_R,   32'h4040, C_HIT,   0, 32'h0,    0};
    vecs[12] = '{0, 32'h0,    2'd0, M_I, OP_INV, 32'h4040, C_HIT,   0, 32'h0,    0};
    vecs[13] = '{1, 32'h5000, 2'd3, M_M, OP_W,   32'h5000, C_NOHIT, 0, 32'h0,    0};
    vecs[14] = '{1, 32'h5000, 2'd1, M_S, OP_R,   32'h5000, C_HIT,   0, 32'h0,    0};
    vecs[15] = '{0, 32'h0,    2'd0, M_I, OP_R,   32'h5400, C_NOHIT, 0, 32'h0,    0};
    vecs[16] = '{0, 32'h0,    2'd0, M_I, OP_X,   32'h5000, C_HIT,   0, 32'h0,    0};
    vecs[17] = '{0, 32'h0,    2'd0, M_I, OP_R,   32'h5000, C_HITM,  1, 32'h5000, 1};
    vecs[18] = '{1, 32'h6000, 2'd0, M_E, OP_INV, 32'h6000, C_NOHIT, 0, 32'h0,    0};
    vecs[19] = '{1, 32'h6000, 2'd0, M_I, OP_R,   32'h6000, C_NOHIT, 0, 32'h0,    0};

    bus.snp_valid  = 1'b1;
    bus.snp_op     = OP_R;
    bus.snp_addr   = 32'h0;
    bus.wb_ready   = 1'b0;
    bus.fill_valid = 1'b1;
    bus.fill_addr  = 32'h0;
    bus.fill_way   = 2'd0;
    bus.fill_mesi  = M_I;

    // Reset: readies held low even with requests pending, outputs at reset values.
    repeat (3) @(posedge clk);
    #1;
    check("reset snp_ready", 32'(bus.snp_ready), 32'd0);
    check("reset fill_ready", 32'(bus.fill_ready), 32'd0);
    bus.snp_valid  = 1'b0;
    bus.fill_valid = 1'b0;
    check("reset C", 32'(bus.C), 32'(C_NOHIT));
    check("reset res_valid", 32'(bus.snp_res_valid), 32'd0);
    check("reset wb_valid", 32'(bus.wb_valid), 32'd0);
    check("reset wb_addr", bus.wb_addr, 32'd0);
    check("reset hit_cntr", 32'(hit_cntr), 32'd0);
    check("reset hitm_cntr", 32'(hitm_cntr), 32'd0);
    rstb = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].do_fill) do_fill(vecs[i].f_addr, vecs[i].f_way, vecs[i].f_mesi);
      run_snoop($sformatf("v%0d", i), vecs[i].op, vecs[i].s_addr, vecs[i].exp_c,
                vecs[i].exp_wb, vecs[i].exp_wba, vecs[i].hold);
    end

    // Fill and snoop in the same IDLE cycle: fill first, snoop next cycle sees it.
    bus.fill_valid = 1'b1;
    bus.fill_addr  = 32'h7040;
    bus.fill_way   = 2'd0;
    bus.fill_mesi  = M_E;
    bus.snp_valid  = 1'b1;
    bus.snp_op     = OP_R;
    bus.snp_addr   = 32'h7040;
    @(negedge clk);
    check("collide fill_ready", 32'(bus.fill_ready), 32'd1);
    check("collide snp_ready", 32'(bus.snp_ready), 32'd0);
    @(posedge clk);
    #1 bus.fill_valid = 1'b0;
    @(negedge clk);
    ok = bus.snp_ready;
    check("collide snoop accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1 bus.snp_valid = 1'b0;
    @(posedge clk); #1;
    check("collide res_valid", 32'(bus.snp_res_valid), 32'd1);
    check("collide C", 32'(bus.C), 32'(C_HIT));
    exp_hit++;
    @(posedge clk); #1;
    check("collide idle", 32'(bus.snp_ready), 32'd1);
    check("collide hit_cntr", 32'(hit_cntr), cnt_exp(exp_hit));
    check("collide hitm_cntr", 32'(hitm_cntr), cnt_exp(exp_hitm));

    // Reset asserted while a writeback is stalled.
    do_fill(32'h8000, 2'd0, M_M);
    bus.snp_valid = 1'b1;
    bus.snp_op    = OP_R;
    bus.snp_addr  = 32'h8000;
    @(negedge clk);
    ok = bus.snp_ready;
    check("rstwb accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1 bus.snp_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("rstwb wb_valid", 32'(bus.wb_valid), 32'd1);
    check("rstwb wb_addr", bus.wb_addr, 32'h8000);
    check("rstwb C", 32'(bus.C), 32'(C_HITM));
    rstb = 1'b1;
    @(posedge clk); #1;
    check("rstwb wb_valid dropped", 32'(bus.wb_valid), 32'd0);
    check("rstwb wb_addr cleared", bus.wb_addr, 32'd0);
    check("rstwb C", 32'(bus.C), 32'(C_NOHIT));
    check("rstwb hit_cntr", 32'(hit_cntr), 32'd0);
    check("rstwb hitm_cntr", 32'(hitm_cntr), 32'd0);
    check("rstwb snp_ready", 32'(bus.snp_ready), 32'd0);
    check("rstwb fill_ready", 32'(bus.fill_ready), 32'd0);
    rstb = 1'b0;
    exp_hit  = 0;
    exp_hitm = 0;
    @(posedge clk); #1;

    // Every previously valid line must now miss.
    probes = '{32'h8000, 32'h5000, 32'h7040, 32'h2040, 32'h4040};
    for (int i = 0; i < 5; i++) begin
      run_snoop($sformatf("post-reset probe %0d", i), OP_R, probes[i], C_NOHIT, 1'b0, 32'h0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
